// File: rtl/german_system_param.sv
// ---------------------------------------------------------------------------
// german_system_param
//
// Parametrised German cache-coherence protocol system. Each cycle the rule
// instance selected by io_en_a (= rule*NODES + node) commits if its guard
// holds; every update of that rule lands on the same rising edge. CtrlProp
// and DataProp are evaluated combinationally on the current registers. A
// sticky flag latches any invariant failure until reset.
//
// Parameters
//   NODES      number of caching nodes (2..8)
//   DATA_W     data value width
//   INIT_DATA  reset value of MemData and AuxData
//   EN_W       width of the rule-select input
//
// Ports
//   clock            system clock
//   reset            synchronous active-high reset
//   io_en_a          flattened rule index, rule*NODES + node
//   io_data          store value (Store rule only)
//   io_fired         registered: selected rule committed last cycle
//   io_ctrl_prop_ok  CtrlProp holds on current state
//   io_data_prop_ok  DataProp holds on current state
//   io_violation     sticky OR of both invariant failures
//   io_cache_state   Cache[i].State at bits [2i+1:2i]
//   io_cur_cmd       CurCmd
//   io_ex_gntd       ExGntd
//   io_fire_cnt      committed-rule count
//
// Optional feature macro: GERMAN_FIRE_CNT_EN
//   defined   -> io_fire_cnt counts committed rules, saturating at all-ones
//   undefined -> no counter logic, io_fire_cnt tied to 0
// ---------------------------------------------------------------------------
module german_system_param #(
    parameter int                NODES     = 3,
    parameter int                DATA_W    = 2,
    parameter logic [DATA_W-1:0] INIT_DATA = '0,
    parameter int                EN_W      = $clog2(12 * NODES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [EN_W-1:0]      io_en_a,
    input  logic [DATA_W-1:0]    io_data,
    output logic                 io_fired,
    output logic                 io_ctrl_prop_ok,
    output logic                 io_data_prop_ok,
    output logic                 io_violation,
    output logic [2*NODES-1:0]   io_cache_state,
    output logic [2:0]           io_cur_cmd,
    output logic                 io_ex_gntd,
    output logic [31:0]          io_fire_cnt
);

    localparam int PTR_W = $clog2(NODES);

    // Cache state encoding
    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;

    // Channel / CurCmd encodings (all channel commands are 3 bits wide)
    localparam logic [2:0] CMD_EMPTY  = 3'd0;
    localparam logic [2:0] CMD_REQS   = 3'd1;
    localparam logic [2:0] CMD_REQE   = 3'd2;
    localparam logic [2:0] CMD_INV    = 3'd1;
    localparam logic [2:0] CMD_GNTS   = 3'd2;
    localparam logic [2:0] CMD_GNTE   = 3'd3;
    localparam logic [2:0] CMD_INVACK = 3'd1;

    // Rule numbers
    localparam int R_STORE        = 0;
    localparam int R_SEND_REQS    = 1;
    localparam int R_SEND_REQE    = 2;
    localparam int R_RECV_REQS    = 3;
    localparam int R_RECV_REQE    = 4;
    localparam int R_SEND_INV     = 5;
    localparam int R_SEND_INVACK  = 6;
    localparam int R_RECV_INVACK  = 7;
    localparam int R_SEND_GNTS    = 8;
    localparam int R_SEND_GNTE    = 9;
    localparam int R_RECV_GNTS    = 10;
    localparam int R_RECV_GNTE    = 11;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [1:0]        cache_state [NODES];
    logic [DATA_W-1:0] cache_data  [NODES];
    logic [2:0]        chan1_cmd   [NODES];
    logic [2:0]        chan2_cmd   [NODES];
    logic [DATA_W-1:0] chan2_data  [NODES];
    logic [2:0]        chan3_cmd   [NODES];
    logic [DATA_W-1:0] chan3_data  [NODES];
    logic [NODES-1:0]  inv_set;
    logic [NODES-1:0]  shr_set;
    logic [2:0]        cur_cmd;
    logic [PTR_W-1:0]  cur_ptr;
    logic              ex_gntd;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] aux_data;
    logic              fired;
    logic              violation;

    // Next-state values produced by the selected rule
    logic [1:0]        cache_state_n [NODES];
    logic [DATA_W-1:0] cache_data_n  [NODES];
    logic [2:0]        chan1_cmd_n   [NODES];
    logic [2:0]        chan2_cmd_n   [NODES];
    logic [DATA_W-1:0] chan2_data_n  [NODES];
    logic [2:0]        chan3_cmd_n   [NODES];
    logic [DATA_W-1:0] chan3_data_n  [NODES];
    logic [NODES-1:0]  inv_set_n;
    logic [NODES-1:0]  shr_set_n;
    logic [2:0]        cur_cmd_n;
    logic [PTR_W-1:0]  cur_ptr_n;
    logic              ex_gntd_n;
    logic [DATA_W-1:0] mem_data_n;
    logic [DATA_W-1:0] aux_data_n;
    logic              fire;

    // ------------------------------------------------------------------
    // Rule-select decode
    // ------------------------------------------------------------------
    logic              in_range;
    logic [EN_W-1:0]   sel_rule;
    logic [EN_W-1:0]   sel_node;
    logic [NODES-1:0]  node_hit;

    // Compare one bit wider so the bound never aliases when 12*NODES
    // happens to need every bit of EN_W.
    assign in_range = ({1'b0, io_en_a} < (EN_W + 1)'(12 * NODES));
    assign sel_rule = io_en_a / EN_W'(NODES);
    assign sel_node = io_en_a % EN_W'(NODES);

    // One-hot node select keeps the node index out of array subscripts.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            node_hit[i] = (sel_node == EN_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Guard evaluation and next-state for the selected rule instance
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            cache_state_n[i] = cache_state[i];
            cache_data_n[i]  = cache_data[i];
            chan1_cmd_n[i]   = chan1_cmd[i];
            chan2_cmd_n[i]   = chan2_cmd[i];
            chan2_data_n[i]  = chan2_data[i];
            chan3_cmd_n[i]   = chan3_cmd[i];
            chan3_data_n[i]  = chan3_data[i];
        end
        inv_set_n  = inv_set;
        shr_set_n  = shr_set;
        cur_cmd_n  = cur_cmd;
        cur_ptr_n  = cur_ptr;
        ex_gntd_n  = ex_gntd;
        mem_data_n = mem_data;
        aux_data_n = aux_data;
        fire       = 1'b0;

        for (int i = 0; i < NODES; i++) begin
            if (in_range && node_hit[i]) begin
                case (sel_rule)
                    EN_W'(R_STORE): begin
                        if (cache_state[i] == ST_E) begin
                            fire            = 1'b1;
                            cache_data_n[i] = io_data;
                            aux_data_n      = io_data;
                        end
                    end
                    EN_W'(R_SEND_REQS): begin
                        if (chan1_cmd[i] == CMD_EMPTY && cache_state[i] == ST_I) begin
                            fire           = 1'b1;
                            chan1_cmd_n[i] = CMD_REQS;
                        end
                    end
                    EN_W'(R_SEND_REQE): begin
                        if (chan1_cmd[i] == CMD_EMPTY &&
                            (cache_state[i] == ST_I || cache_state[i] == ST_S)) begin
                            fire           = 1'b1;
                            chan1_cmd_n[i] = CMD_REQE;
                        end
                    end
                    EN_W'(R_RECV_REQS): begin
                        if (cur_cmd == CMD_EMPTY && chan1_cmd[i] == CMD_REQS) begin
                            fire           = 1'b1;
                            cur_cmd_n      = CMD_REQS;
                            cur_ptr_n      = PTR_W'(i);
                            chan1_cmd_n[i] = CMD_EMPTY;
                            // Every current sharer must be invalidated if needed.
                            inv_set_n      = shr_set;
                        end
                    end
                    EN_W'(R_RECV_REQE): begin
                        if (cur_cmd == CMD_EMPTY && chan1_cmd[i] == CMD_REQE) begin
                            fire           = 1'b1;
                            cur_cmd_n      = CMD_REQE;
                            cur_ptr_n      = PTR_W'(i);
                            chan1_cmd_n[i] = CMD_EMPTY;
                            inv_set_n      = shr_set;
                        end
                    end
                    EN_W'(R_SEND_INV): begin
                        // A shared request only needs invalidation when an
                        // exclusive copy exists.
                        if (chan2_cmd[i] == CMD_EMPTY && inv_set[i] &&
                            (cur_cmd == CMD_REQE || (cur_cmd == CMD_REQS && ex_gntd))) begin
                            fire           = 1'b1;
                            chan2_cmd_n[i] = CMD_INV;
                            inv_set_n[i]   = 1'b0;
                        end
                    end
                    EN_W'(R_SEND_INVACK): begin
                        if (chan2_cmd[i] == CMD_INV && chan3_cmd[i] == CMD_EMPTY) begin
                            fire           = 1'b1;
                            chan2_cmd_n[i] = CMD_EMPTY;
                            chan3_cmd_n[i] = CMD_INVACK;
                            // Only an exclusive owner carries dirty data back.
                            if (cache_state[i] == ST_E) begin
                                chan3_data_n[i] = cache_data[i];
                            end
                            cache_state_n[i] = ST_I;
                        end
                    end
                    EN_W'(R_RECV_INVACK): begin
                        if (chan3_cmd[i] == CMD_INVACK && cur_cmd != CMD_EMPTY) begin
                            fire           = 1'b1;
                            chan3_cmd_n[i] = CMD_EMPTY;
                            shr_set_n[i]   = 1'b0;
                            if (ex_gntd) begin
                                ex_gntd_n  = 1'b0;
                                mem_data_n = chan3_data[i];
                            end
                        end
                    end
                    EN_W'(R_SEND_GNTS): begin
                        if (cur_cmd == CMD_REQS && cur_ptr == PTR_W'(i) &&
                            chan2_cmd[i] == CMD_EMPTY && !ex_gntd) begin
                            fire            = 1'b1;
                            chan2_cmd_n[i]  = CMD_GNTS;
                            chan2_data_n[i] = mem_data;
                            shr_set_n[i]    = 1'b1;
                            cur_cmd_n       = CMD_EMPTY;
                        end
                    end
                    EN_W'(R_SEND_GNTE): begin
                        if (cur_cmd == CMD_REQE && cur_ptr == PTR_W'(i) &&
                            chan2_cmd[i] == CMD_EMPTY && !ex_gntd &&
                            shr_set == '0) begin
                            fire            = 1'b1;
                            chan2_cmd_n[i]  = CMD_GNTE;
                            chan2_data_n[i] = mem_data;
                            shr_set_n[i]    = 1'b1;
                            ex_gntd_n       = 1'b1;
                            cur_cmd_n       = CMD_EMPTY;
                        end
                    end
                    EN_W'(R_RECV_GNTS): begin
                        if (chan2_cmd[i] == CMD_GNTS) begin
                            fire             = 1'b1;
                            cache_state_n[i] = ST_S;
                            cache_data_n[i]  = chan2_data[i];
                            chan2_cmd_n[i]   = CMD_EMPTY;
                        end
                    end
                    EN_W'(R_RECV_GNTE): begin
                        if (chan2_cmd[i] == CMD_GNTE) begin
                            fire             = 1'b1;
                            cache_state_n[i] = ST_E;
                            cache_data_n[i]  = chan2_data[i];
                            chan2_cmd_n[i]   = CMD_EMPTY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State register: one rule commits per edge, reset wins
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NODES; i++) begin
                cache_state[i] <= ST_I;
                cache_data[i]  <= '0;
                chan1_cmd[i]   <= CMD_EMPTY;
                chan2_cmd[i]   <= CMD_EMPTY;
                chan2_data[i]  <= '0;
                chan3_cmd[i]   <= CMD_EMPTY;
                chan3_data[i]  <= '0;
            end
            inv_set  <= '0;
            shr_set  <= '0;
            cur_cmd  <= CMD_EMPTY;
            cur_ptr  <= '0;
            ex_gntd  <= 1'b0;
            mem_data <= INIT_DATA;
            aux_data <= INIT_DATA;
            fired    <= 1'b0;
        end else begin
            for (int i = 0; i < NODES; i++) begin
                cache_state[i] <= cache_state_n[i];
                cache_data[i]  <= cache_data_n[i];
                chan1_cmd[i]   <= chan1_cmd_n[i];
                chan2_cmd[i]   <= chan2_cmd_n[i];
                chan2_data[i]  <= chan2_data_n[i];
                chan3_cmd[i]   <= chan3_cmd_n[i];
                chan3_data[i]  <= chan3_data_n[i];
            end
            inv_set  <= inv_set_n;
            shr_set  <= shr_set_n;
            cur_cmd  <= cur_cmd_n;
            cur_ptr  <= cur_ptr_n;
            ex_gntd  <= ex_gntd_n;
            mem_data <= mem_data_n;
            aux_data <= aux_data_n;
            fired    <= fire;
        end
    end

    // ------------------------------------------------------------------
    // Invariant monitors on the current registers
    // ------------------------------------------------------------------
    logic ctrl_ok;
    logic data_ok;

    always_comb begin
        ctrl_ok = 1'b1;
        for (int i = 0; i < NODES; i++) begin
            for (int j = 0; j < NODES; j++) begin
                if (i != j) begin
                    if (cache_state[i] == ST_E && cache_state[j] != ST_I) begin
                        ctrl_ok = 1'b0;
                    end
                    if (cache_state[i] == ST_S &&
                        cache_state[j] != ST_I && cache_state[j] != ST_S) begin
                        ctrl_ok = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        // Memory is only authoritative while no exclusive copy is out.
        data_ok = ex_gntd || (mem_data == aux_data);
        for (int i = 0; i < NODES; i++) begin
            if (cache_state[i] != ST_I && cache_data[i] != aux_data) begin
                data_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            violation <= 1'b0;
        end else if (!ctrl_ok || !data_ok) begin
            violation <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Committed-rule counter
    // ------------------------------------------------------------------
`ifdef GERMAN_FIRE_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] fire_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            fire_cnt <= '0;
        end else if (fire) begin
            fire_cnt <= sat_inc(fire_cnt);
        end
    end

    assign io_fire_cnt = fire_cnt;
`else
    assign io_fire_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        io_cache_state = '0;
        for (int i = 0; i < NODES; i++) begin
            io_cache_state[2*i +: 2] = cache_state[i];
        end
    end

    assign io_fired        = fired;
    assign io_ctrl_prop_ok = ctrl_ok;
    assign io_data_prop_ok = data_ok;
    assign io_violation    = violation;
    assign io_cur_cmd      = cur_cmd;
    assign io_ex_gntd      = ex_gntd;

endmodule

// File: tb/tb_german_system_param.sv
// ---------------------------------------------------------------------------
// tb_german_system_param
//
// Self-checking bench for german_system_param (NODES=3, DATA_W=2,
// INIT_DATA=0). A table of hand-derived vectors walks the shared, exclusive,
// invalidation, blocked-guard and mid-transaction-reset scenarios; a random
// phase then compares every cycle with an abstract protocol model.
// ---------------------------------------------------------------------------
module tb_german_system_param;

    localparam int NODES  = 3;
    localparam int DATA_W = 2;
    localparam int EN_W   = 6;
    localparam int NINST  = 12 * NODES;

    logic                clock = 1'b0;
    logic                reset;
    logic [EN_W-1:0]     en_a;
    logic [DATA_W-1:0]   data;
    logic                fired;
    logic                ctrl_ok;
    logic                data_ok;
    logic                violation;
    logic [2*NODES-1:0]  cache_state;
    logic [2:0]          cur_cmd;
    logic                ex_gntd;
    logic [31:0]         fire_cnt;

    german_system_param #(
        .NODES    (NODES),
        .DATA_W   (DATA_W),
        .INIT_DATA(2'd0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_en_a        (en_a),
        .io_data        (data),
        .io_fired       (fired),
        .io_ctrl_prop_ok(ctrl_ok),
        .io_data_prop_ok(data_ok),
        .io_violation   (violation),
        .io_cache_state (cache_state),
        .io_cur_cmd     (cur_cmd),
        .io_ex_gntd     (ex_gntd),
        .io_fire_cnt    (fire_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- abstract reference model ----------------
    int     m_state [NODES];
    int     m_data  [NODES];
    int     m_c1    [NODES];
    int     m_c2    [NODES];
    int     m_c2d   [NODES];
    int     m_c3    [NODES];
    int     m_c3d   [NODES];
    bit     m_inv   [NODES];
    bit     m_shr   [NODES];
    int     m_cur, m_ptr, m_mem, m_aux;
    bit     m_exg, m_fired, m_viol;
    longint m_cnt;

    // At most one exclusive holder, and never alongside any other copy.
    function automatic bit model_ctrl_ok();
        int ne = 0;
        int ns = 0;
        for (int i = 0; i < NODES; i++) begin
            if (m_state[i] == 2) ne++;
            if (m_state[i] == 1) ns++;
        end
        return (ne == 0) || (ne == 1 && ns == 0);
    endfunction

    function automatic bit model_data_ok();
        bit ok = m_exg || (m_mem == m_aux);
        for (int i = 0; i < NODES; i++)
            if (m_state[i] != 0 && m_data[i] != m_aux) ok = 0;
        return ok;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NODES; i++) begin
            m_state[i] = 0; m_data[i] = 0; m_c1[i] = 0; m_c2[i] = 0;
            m_c2d[i] = 0; m_c3[i] = 0; m_c3d[i] = 0; m_inv[i] = 0; m_shr[i] = 0;
        end
        m_cur = 0; m_ptr = 0; m_mem = 0; m_aux = 0;
        m_exg = 0; m_fired = 0; m_viol = 0; m_cnt = 0;
    endtask

    task automatic model_step(input int en, input int d);
        int  r, n;
        bit  any_shr;
        m_viol  = m_viol | !model_ctrl_ok() | !model_data_ok();
        m_fired = 0;
        if (en < NINST) begin
            r = en / NODES;
            n = en % NODES;
            any_shr = 0;
            for (int j = 0; j < NODES; j++) any_shr |= m_shr[j];
            case (r)
                0: if (m_state[n] == 2) begin
                       m_data[n] = d; m_aux = d; m_fired = 1;
                   end
                1: if (m_c1[n] == 0 && m_state[n] == 0) begin
                       m_c1[n] = 1; m_fired = 1;
                   end
                2: if (m_c1[n] == 0 && m_state[n] != 2) begin
                       m_c1[n] = 2; m_fired = 1;
                   end
                3, 4: if (m_cur == 0 && m_c1[n] == r - 2) begin
                       m_cur = r - 2; m_ptr = n; m_c1[n] = 0; m_fired = 1;
                       for (int j = 0; j < NODES; j++) m_inv[j] = m_shr[j];
                   end
                5: if (m_c2[n] == 0 && m_inv[n] && (m_cur == 2 || (m_cur == 1 && m_exg))) begin
                       m_c2[n] = 1; m_inv[n] = 0; m_fired = 1;
                   end
                6: if (m_c2[n] == 1 && m_c3[n] == 0) begin
                       m_c2[n] = 0; m_c3[n] = 1;
                       if (m_state[n] == 2) m_c3d[n] = m_data[n];
                       m_state[n] = 0; m_fired = 1;
                   end
                7: if (m_c3[n] == 1 && m_cur != 0) begin
                       m_c3[n] = 0; m_shr[n] = 0; m_fired = 1;
                       if (m_exg) begin m_exg = 0; m_mem = m_c3d[n]; end
                   end
                8: if (m_cur == 1 && m_ptr == n && m_c2[n] == 0 && !m_exg) begin
                       m_c2[n] = 2; m_c2d[n] = m_mem; m_shr[n] = 1; m_cur = 0; m_fired = 1;
                   end
                9: if (m_cur == 2 && m_ptr == n && m_c2[n] == 0 && !m_exg && !any_shr) begin
                       m_c2[n] = 3; m_c2d[n] = m_mem; m_shr[n] = 1; m_exg = 1;
                       m_cur = 0; m_fired = 1;
                   end
                10, 11: if (m_c2[n] == r - 8) begin
                       m_state[n] = r - 9; m_data[n] = m_c2d[n]; m_c2[n] = 0; m_fired = 1;
                   end
                default: ;
            endcase
        end
        if (m_fired && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [2*NODES-1:0] exp_cs;
        longint             exp_cnt;
        exp_cs = '0;
        for (int i = 0; i < NODES; i++) exp_cs[2*i +: 2] = 2'(m_state[i]);
`ifdef GERMAN_FIRE_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check({tag, "_fired"},     64'(fired),       64'(m_fired));
        check({tag, "_cache"},     64'(cache_state), 64'(exp_cs));
        check({tag, "_curcmd"},    64'(cur_cmd),     64'(m_cur));
        check({tag, "_exgntd"},    64'(ex_gntd),     64'(m_exg));
        check({tag, "_ctrlok"},    64'(ctrl_ok),     64'(model_ctrl_ok()));
        check({tag, "_dataok"},    64'(data_ok),     64'(model_data_ok()));
        check({tag, "_violation"}, 64'(violation),   64'(m_viol));
        check({tag, "_firecnt"},   64'(fire_cnt),    64'(exp_cnt));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input int en, input int d);
        en_a = EN_W'(en);
        data = DATA_W'(d);
        model_step(en, d);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en_a  = EN_W'(NINST);
        data  = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check("rst_fired",     64'(fired),       64'd0);
        check("rst_cache",     64'(cache_state), 64'd0);
        check("rst_curcmd",    64'(cur_cmd),     64'd0);
        check("rst_exgntd",    64'(ex_gntd),     64'd0);
        check("rst_violation", 64'(violation),   64'd0);
        check("rst_firecnt",   64'(fire_cnt),    64'd0);
        check("rst_ctrlok",    64'(ctrl_ok),     64'd1);
        check("rst_dataok",    64'(data_ok),     64'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst;
        int en;
        int d;
        bit fired;
        int cs;
        int cmd;
        bit exg;
        bit dok;
    } vec_t;

    function automatic vec_t mk(bit rst, int en, int d, bit f, int cs, int cmd, bit exg, bit dok);
        vec_t v;
        v.rst = rst; v.en = en; v.d = d; v.fired = f;
        v.cs = cs; v.cmd = cmd; v.exg = exg; v.dok = dok;
        return v;
    endfunction

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        en_a  = EN_W'(NINST);
        data  = '0;
        model_reset();

        //             rst en  d  fired cs  cmd exg dok
        tbl[0]  = mk(1, 36, 0, 0,  0, 0, 0, 1);  // idle after reset
        tbl[1]  = mk(0,  4, 0, 1,  0, 0, 0, 1);  // SendReqS n1
        tbl[2]  = mk(0, 10, 0, 1,  0, 1, 0, 1);  // RecvReqS n1
        tbl[3]  = mk(0, 25, 0, 1,  0, 0, 0, 1);  // SendGntS n1
        tbl[4]  = mk(0, 31, 0, 1,  4, 0, 0, 1);  // RecvGntS n1 -> S
        tbl[5]  = mk(1,  6, 0, 1,  0, 0, 0, 1);  // SendReqE n0
        tbl[6]  = mk(0, 12, 0, 1,  0, 2, 0, 1);  // RecvReqE n0
        tbl[7]  = mk(0, 27, 0, 1,  0, 0, 1, 1);  // SendGntE n0
        tbl[8]  = mk(0, 33, 0, 1,  2, 0, 1, 1);  // RecvGntE n0 -> E
        tbl[9]  = mk(0,  0, 3, 1,  2, 0, 1, 1);  // Store 3 on n0
        tbl[10] = mk(0,  8, 0, 1,  2, 0, 1, 1);  // SendReqE n2
        tbl[11] = mk(0, 14, 0, 1,  2, 2, 1, 1);  // RecvReqE n2
        tbl[12] = mk(0, 15, 0, 1,  2, 2, 1, 1);  // SendInv n0
        tbl[13] = mk(0, 18, 0, 1,  0, 2, 1, 1);  // SendInvAck n0 -> I
        tbl[14] = mk(0, 21, 0, 1,  0, 2, 0, 1);  // RecvInvAck n0, Mem=3
        tbl[15] = mk(0, 29, 0, 1,  0, 0, 1, 1);  // SendGntE n2
        tbl[16] = mk(0, 35, 0, 1, 32, 0, 1, 1);  // RecvGntE n2 -> E
        tbl[17] = mk(0, 24, 0, 0, 32, 0, 1, 1);  // SendGntS n0 blocked
        tbl[18] = mk(0,  0, 1, 0, 32, 0, 1, 1);  // Store on invalid n0 blocked
        tbl[19] = mk(0, 40, 2, 0, 32, 0, 1, 1);  // out-of-range index
        tbl[20] = mk(1,  4, 0, 1,  0, 0, 0, 1);  // SendReqS n1
        tbl[21] = mk(0, 10, 0, 1,  0, 1, 0, 1);  // RecvReqS n1 (in flight)
        tbl[22] = mk(1, 36, 0, 0,  0, 0, 0, 1);  // reset mid-transaction

        @(negedge clock);
        for (int k = 0; k < NVEC; k++) begin
            if (tbl[k].rst) do_reset();
            step(tbl[k].en, tbl[k].d);
            check($sformatf("vec%0d_fired", k),  64'(fired),       64'(tbl[k].fired));
            check($sformatf("vec%0d_cache", k),  64'(cache_state), 64'(tbl[k].cs));
            check($sformatf("vec%0d_curcmd", k), 64'(cur_cmd),     64'(tbl[k].cmd));
            check($sformatf("vec%0d_exgntd", k), 64'(ex_gntd),     64'(tbl[k].exg));
            check($sformatf("vec%0d_dataok", k), 64'(data_ok),     64'(tbl[k].dok));
            check_model($sformatf("vec%0d_model", k));
`ifdef GERMAN_FIRE_CNT_EN
            if (k == 15) check("firecnt_after_invalidation", 64'(fire_cnt), 64'd11);
`endif
        end

        // ---------------- randomized phase ----------------
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 1000; c++) begin
                int en;
                int d;
                en = int'($urandom_range(0, NINST + 3));
                d  = int'($urandom_range(0, 3));
                step(en, d);
                check_model($sformatf("rnd%0d_%0d", blk, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
